// File: rtl/multi_rate_flasher_if.sv
// Configuration write port of multi_rate_flasher: one-clock strobe plus channel address and settings.
interface multi_rate_flasher_if #(
  parameter int CH_BITS  = 2,
  parameter int DIV_BITS = 16
);
  logic                cfg_we;
  logic [CH_BITS-1:0]  cfg_ch;
  logic [1:0]          cfg_mode;
  logic [DIV_BITS-1:0] cfg_div;
  logic [DIV_BITS-1:0] cfg_duty;

  modport master (output cfg_we, cfg_ch, cfg_mode, cfg_div, cfg_duty);
  modport slave  (input  cfg_we, cfg_ch, cfg_mode, cfg_div, cfg_duty);
endinterface

// File: rtl/multi_rate_flasher.sv
// N-channel LED flasher / clock-enable generator: shared prescaler feeding per-channel
// programmable dividers, each driving an LED in OFF, ON, SQUARE or PWM mode.
//
//   mode   | meaning
//   OFF    | led held low
//   ON     | led held high
//   SQUARE | led toggles on every channel wrap (50% duty)
//   PWM    | led high while the counter is below duty
module multi_rate_flasher #(
  parameter int CHANNELS      = 4,
  parameter int CH_BITS       = 2,
  parameter int PRESCALE      = 100,
  parameter int PRESCALE_BITS = 7,
  parameter int DIV_BITS      = 16,
  parameter int DEFAULT_DIV   = 99
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  multi_rate_flasher_if.slave  cfg,
  output logic                 pre_tick,
  output logic [CHANNELS-1:0]  tick_out,
  output logic [CHANNELS-1:0]  led_out
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_ON     = 2'b01,
    MODE_SQUARE = 2'b10,
    MODE_PWM    = 2'b11
  } mode_t;

  logic [PRESCALE_BITS-1:0] pcnt;
  logic                     pre_wrap;
  logic                     step_pend;
  logic                     ch_step;

  assign pre_wrap = (pcnt == PRESCALE_BITS'(PRESCALE - 1));

  // step_pend mirrors pre_tick but is held (not cleared) while frozen, so a
  // prescaler wrap seen just before enable drops is still applied on resume.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt      <= '0;
      pre_tick  <= 1'b0;
      step_pend <= 1'b0;
    end else if (enable) begin
      pcnt      <= pre_wrap ? '0 : pcnt + 1'b1;
      pre_tick  <= pre_wrap;
      step_pend <= pre_wrap;
    end else begin
      pre_tick  <= 1'b0;
    end
  end

  assign ch_step = enable && step_pend;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : gen_ch
    mode_t               mode;
    logic [DIV_BITS-1:0] div;
    logic [DIV_BITS-1:0] duty;
    logic [DIV_BITS-1:0] cnt;
    logic [DIV_BITS-1:0] cnt_next;
    logic                cnt_wrap;
    logic                wr_hit;
    logic                tick_q;
    logic                led_q;

    // Addresses at or above CHANNELS match no channel and are dropped.
    assign wr_hit   = cfg.cfg_we && (cfg.cfg_ch == CH_BITS'(gi));
    assign cnt_wrap = (cnt == div);
    assign cnt_next = cnt_wrap ? '0 : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mode   <= MODE_OFF;
        div    <= DIV_BITS'(DEFAULT_DIV);
        duty   <= '0;
        cnt    <= '0;
        tick_q <= 1'b0;
        led_q  <= 1'b0;
      end else if (wr_hit) begin
        mode   <= mode_t'(cfg.cfg_mode);
        div    <= cfg.cfg_div;
        duty   <= cfg.cfg_duty;
        cnt    <= '0;
        tick_q <= 1'b0;
        led_q  <= (cfg.cfg_mode == MODE_ON);
      end else if (ch_step) begin
        cnt    <= cnt_next;
        tick_q <= cnt_wrap;
        case (mode)
          MODE_OFF:    led_q <= 1'b0;
          MODE_ON:     led_q <= 1'b1;
          MODE_SQUARE: led_q <= led_q ^ cnt_wrap;
          MODE_PWM:    led_q <= (cnt_next < duty);
        endcase
      end else begin
        tick_q <= 1'b0;
      end
    end

    assign tick_out[gi] = tick_q;
    assign led_out[gi]  = led_q;
  end

endmodule

// File: tb/tb_multi_rate_flasher.sv
// Bench for multi_rate_flasher (PRESCALE=4, DIV_BITS=8): expected strobe times are queued
// when a channel is programmed and popped as the DUT produces them.
module tb_multi_rate_flasher;

  localparam logic [1:0] M_OFF = 2'b00;
  localparam logic [1:0] M_ON  = 2'b01;
  localparam logic [1:0] M_SQ  = 2'b10;
  localparam logic [1:0] M_PWM = 2'b11;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       pre_tick;
  logic [3:0] tick_out;
  logic [3:0] led_out;
  logic       pre_tick2;
  logic [2:0] tick_out2;
  logic [2:0] led_out2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  multi_rate_flasher_if #(.CH_BITS(2), .DIV_BITS(8)) cfg_a ();
  multi_rate_flasher_if #(.CH_BITS(2), .DIV_BITS(8)) cfg_b ();

  multi_rate_flasher #(
    .CHANNELS(4), .CH_BITS(2), .PRESCALE(4), .PRESCALE_BITS(2), .DIV_BITS(8), .DEFAULT_DIV(99)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfg(cfg_a),
    .pre_tick(pre_tick), .tick_out(tick_out), .led_out(led_out)
  );

  // Three-channel instance: address 3 is out of range here.
  multi_rate_flasher #(
    .CHANNELS(3), .CH_BITS(2), .PRESCALE(4), .PRESCALE_BITS(2), .DIV_BITS(8), .DEFAULT_DIV(99)
  ) dut3 (
    .clk(clk), .rst(rst), .enable(enable), .cfg(cfg_b),
    .pre_tick(pre_tick2), .tick_out(tick_out2), .led_out(led_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, need completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_pre_tick();
    int n = 0;
    @(negedge clk);
    while (pre_tick !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (pre_tick !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL align: pre_tick=%b after %0d clks, need 1", pre_tick, n);
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] mode,
                           input logic [7:0] div, input logic [7:0] duty);
    cfg_a.cfg_ch   = ch;
    cfg_a.cfg_mode = mode;
    cfg_a.cfg_div  = div;
    cfg_a.cfg_duty = duty;
    cfg_a.cfg_we   = 1'b1;
    @(negedge clk);
    cfg_a.cfg_we   = 1'b0;
  endtask

  task automatic test_reset();
    int exp_q[$];
    int n = 0;
    int base;
    int e;
    rst    = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (pre_tick !== 1'b0) begin n_err++; $display("FAIL rst_pre_tick: got %b need 0", pre_tick); end
    n_cmp++; if (tick_out !== 4'h0) begin n_err++; $display("FAIL rst_tick_out: got %h need 0", tick_out); end
    n_cmp++; if (led_out !== 4'h0)  begin n_err++; $display("FAIL rst_led_out: got %h need 0", led_out); end
    rst    = 1'b1;
    enable = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (pre_tick) n++;
    end
    n_cmp++; if (n !== 0) begin n_err++; $display("FAIL disabled_pre_tick: got %0d strobes need 0", n); end
    enable = 1'b1;
    base = cyc;
    exp_q.push_back(base + 4);
    exp_q.push_back(base + 8);
    exp_q.push_back(base + 12);
    repeat (14) begin
      @(negedge clk);
      if (pre_tick) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL pre_tick_time: got strobe at %0d need none", cyc - base);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e) begin n_err++; $display("FAIL pre_tick_time: got %0d need %0d", cyc - base, e - base); end
        end
      end
    end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL pre_tick_missing: got %0d unseen need 0", exp_q.size()); end
  endtask

  task automatic test_square();
    int exp_q[$];
    int w;
    int e;
    int c;
    logic exp_led;
    wait_pre_tick();
    w = cyc;
    cfg_write(2'd0, M_SQ, 8'd2, 8'd0);
    exp_q.push_back(w + 13);
    exp_q.push_back(w + 25);
    exp_q.push_back(w + 37);
    while (cyc < w + 40) begin
      @(negedge clk);
      c = cyc - w;
      exp_led = (c >= 13) ? (((c - 13) / 12) % 2 == 0) : 1'b0;
      n_cmp++;
      if (led_out[0] !== exp_led) begin n_err++; $display("FAIL square_led @%0d: got %b need %b", c, led_out[0], exp_led); end
      if (tick_out[0]) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL square_tick: got strobe at %0d need none", c);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e) begin n_err++; $display("FAIL square_tick: got %0d need %0d", c, e - w); end
        end
      end
    end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL square_missing: got %0d unseen need 0", exp_q.size()); end
  endtask

  task automatic test_pwm();
    int exp_q[$];
    int w;
    int e;
    int hi;
    wait_pre_tick();
    w = cyc;
    cfg_write(2'd1, M_PWM, 8'd9, 8'd3);
    for (int j = 0; j < 10; j++) exp_q.push_back(w + 41 + 40 * j);
    hi = 0;
    while (cyc < w + 404) begin
      @(negedge clk);
      if (cyc >= w + 5 && led_out[1]) hi++;
      if (tick_out[1]) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL pwm_tick: got strobe at %0d need none", cyc - w);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e) begin n_err++; $display("FAIL pwm_tick: got %0d need %0d", cyc - w, e - w); end
        end
      end
    end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL pwm_missing: got %0d unseen need 0", exp_q.size()); end
    n_cmp++; if (hi !== 120) begin n_err++; $display("FAIL pwm_duty3_high: got %0d clks need 120", hi); end

    wait_pre_tick();
    w = cyc;
    cfg_write(2'd1, M_PWM, 8'd9, 8'd0);
    hi = 0;
    while (cyc < w + 101) begin
      @(negedge clk);
      if (led_out[1]) hi++;
    end
    n_cmp++; if (hi !== 0) begin n_err++; $display("FAIL pwm_duty0_high: got %0d clks need 0", hi); end

    wait_pre_tick();
    w = cyc;
    cfg_write(2'd1, M_PWM, 8'd9, 8'd12);
    hi = 0;
    while (cyc < w + 104) begin
      @(negedge clk);
      if (cyc == w + 2) begin
        n_cmp++; if (led_out[1] !== 1'b0) begin n_err++; $display("FAIL pwm_write_led: got %b need 0", led_out[1]); end
      end
      if (cyc >= w + 5 && led_out[1]) hi++;
    end
    n_cmp++; if (hi !== 100) begin n_err++; $display("FAIL pwm_duty12_high: got %0d clks need 100", hi); end
  endtask

  task automatic test_mid_write();
    int q0[$];
    int q2[$];
    int w;
    int e;
    wait_pre_tick();
    w = cyc;
    cfg_write(2'd0, M_SQ, 8'd2, 8'd0);
    cfg_write(2'd2, M_SQ, 8'd5, 8'd0);
    for (int j = 0; j < 6; j++) q0.push_back(w + 13 + 12 * j);
    q2.push_back(w + 25);
    q2.push_back(w + 57);
    q2.push_back(w + 65);
    q2.push_back(w + 73);
    while (cyc < w + 76) begin
      @(negedge clk);
      cfg_a.cfg_we = 1'b0;
      if (cyc == w + 48) begin
        n_cmp++; if (pre_tick !== 1'b1) begin n_err++; $display("FAIL mid_pre_tick: got %b need 1", pre_tick); end
        n_cmp++; if (led_out[2] !== 1'b1) begin n_err++; $display("FAIL mid_led_before: got %b need 1", led_out[2]); end
        cfg_a.cfg_ch   = 2'd2;
        cfg_a.cfg_mode = M_SQ;
        cfg_a.cfg_div  = 8'd1;
        cfg_a.cfg_duty = 8'd0;
        cfg_a.cfg_we   = 1'b1;
      end
      if (cyc == w + 49) begin
        n_cmp++; if (led_out[2] !== 1'b0) begin n_err++; $display("FAIL mid_led_after: got %b need 0", led_out[2]); end
      end
      if (cyc == w + 57) begin
        n_cmp++; if (led_out[2] !== 1'b1) begin n_err++; $display("FAIL mid_led_retick: got %b need 1", led_out[2]); end
      end
      if (tick_out[0]) begin
        n_cmp++;
        if (q0.size() == 0) begin
          n_err++; $display("FAIL mid_ch0_tick: got strobe at %0d need none", cyc - w);
        end else begin
          e = q0.pop_front();
          if (cyc !== e) begin n_err++; $display("FAIL mid_ch0_tick: got %0d need %0d", cyc - w, e - w); end
        end
      end
      if (tick_out[2]) begin
        n_cmp++;
        if (q2.size() == 0) begin
          n_err++; $display("FAIL mid_ch2_tick: got strobe at %0d need none", cyc - w);
        end else begin
          e = q2.pop_front();
          if (cyc !== e) begin n_err++; $display("FAIL mid_ch2_tick: got %0d need %0d", cyc - w, e - w); end
        end
      end
    end
    n_cmp++; if (q0.size() + q2.size() !== 0) begin n_err++; $display("FAIL mid_missing: got %0d unseen need 0", q0.size() + q2.size()); end
    n_cmp++; if (led_out[1] !== 1'b1) begin n_err++; $display("FAIL mid_ch1_led: got %b need 1", led_out[1]); end
  endtask

  task automatic test_freeze();
    int exp_q[$];
    int w;
    int e;
    wait_pre_tick();
    w = cyc;
    cfg_write(2'd0, M_SQ, 8'd2, 8'd0);
    exp_q.push_back(w + 20);
    exp_q.push_back(w + 32);
    while (cyc < w + 34) begin
      @(negedge clk);
      if (cyc == w + 6)  enable = 1'b0;
      if (cyc == w + 13) enable = 1'b1;
      if (cyc >= w + 7 && cyc <= w + 13) begin
        n_cmp++;
        if ({pre_tick, tick_out} !== 5'b0) begin n_err++; $display("FAIL freeze_strobe @%0d: got %b need 0", cyc - w, {pre_tick, tick_out}); end
        n_cmp++;
        if (led_out[1:0] !== 2'b10) begin n_err++; $display("FAIL freeze_led @%0d: got %b need 10", cyc - w, led_out[1:0]); end
      end
      if (tick_out[0]) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL freeze_tick: got strobe at %0d need none", cyc - w);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e) begin n_err++; $display("FAIL freeze_tick: got %0d need %0d", cyc - w, e - w); end
        end
      end
    end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL freeze_missing: got %0d unseen need 0", exp_q.size()); end
  endtask

  task automatic test_edges();
    int exp_q[$];
    int w;
    int e;
    wait_pre_tick();
    w = cyc;
    cfg_write(2'd3, M_SQ, 8'd0, 8'd0);
    for (int j = 0; j < 4; j++) exp_q.push_back(w + 5 + 4 * j);
    while (cyc < w + 19) begin
      @(negedge clk);
      if (tick_out[3]) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL div0_tick: got strobe at %0d need none", cyc - w);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e) begin n_err++; $display("FAIL div0_tick: got %0d need %0d", cyc - w, e - w); end
        end
      end
    end
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL div0_missing: got %0d unseen need 0", exp_q.size()); end

    cfg_b.cfg_ch   = 2'd3;
    cfg_b.cfg_mode = M_ON;
    cfg_b.cfg_div  = 8'd0;
    cfg_b.cfg_duty = 8'd0;
    cfg_b.cfg_we   = 1'b1;
    @(negedge clk);
    cfg_b.cfg_we   = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (led_out2 !== 3'b000) begin n_err++; $display("FAIL illegal_ch: got %b need 000", led_out2); end
    cfg_b.cfg_ch   = 2'd2;
    cfg_b.cfg_we   = 1'b1;
    @(negedge clk);
    cfg_b.cfg_we   = 1'b0;
    n_cmp++; if (led_out2 !== 3'b100) begin n_err++; $display("FAIL legal_ch: got %b need 100", led_out2); end

    @(negedge clk);
    n_cmp++; if (led_out[1] !== 1'b1) begin n_err++; $display("FAIL pre_async_led: got %b need 1", led_out[1]); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (led_out !== 4'h0)  begin n_err++; $display("FAIL async_led: got %h need 0", led_out); end
    n_cmp++; if (led_out2 !== 3'b0) begin n_err++; $display("FAIL async_led3: got %b need 000", led_out2); end
    n_cmp++; if ({pre_tick, tick_out} !== 5'b0) begin n_err++; $display("FAIL async_strobes: got %b need 0", {pre_tick, tick_out}); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst            = 1'b0;
    enable         = 1'b1;
    cfg_a.cfg_we   = 1'b0;
    cfg_a.cfg_ch   = '0;
    cfg_a.cfg_mode = '0;
    cfg_a.cfg_div  = '0;
    cfg_a.cfg_duty = '0;
    cfg_b.cfg_we   = 1'b0;
    cfg_b.cfg_ch   = '0;
    cfg_b.cfg_mode = '0;
    cfg_b.cfg_div  = '0;
    cfg_b.cfg_duty = '0;
    test_reset();
    test_square();
    test_pwm();
    test_mid_write();
    test_freeze();
    test_edges();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
